systolic_feeder: RTL and testbench
==================================

// Module: systolic_feeder
// PURPOSE
//  Transmit side of the PE-array operand interface. Buffers matrix A (B x K) and W (K x B), then streams them
//  diagonally skewed into the west (data) and north (weight) edges of a B x B grid of DP PEs.
//  Clears the array accumulators before streaming. Pulses done when every PE result is final.
// PARAMETERS
//  B               4  array dimension (rows = columns)
//  K               4  inner (reduction) dimension, >= 1
//  quantized_width 8  signed operand width (QW)
// PORTS
//  clk_i        in   1      clock
//  reset_i      in   1      reset, synchronous, active-high
//  load_valid_i in   1      load beat valid
//  load_ready_o out  1      load beat accepted when valid&ready
//  load_sel_i   in   1      0: beat is A column A[0..B-1][k]; 1: beat is W row W[k][0..B-1]
//  load_data_i  in   B*QW   lane i at bits [i*QW +: QW]
//  start_i      in   1      start request
//  busy_o       out  1      high in CLEAR and STREAM
//  acc_clr_o    out  1      one-cycle accumulator clear to array reset_i
//  data_o       out  B*QW   lane r drives PE row r data_i
//  weight_o     out  B*QW   lane c drives PE column c weight_i
//  done_o       out  1      one-cycle pulse, array results final
// BEHAVIOUR
//  - Reset: state IDLE, all outputs 0 except load_ready_o=1, both load counters 0, a_full=w_full=0. Buffer contents don't-care.
//  - A reset asserted in any state, including mid-STREAM, takes effect next edge. Reload is required afterwards.
//  - FSM: IDLE -> CLEAR (1 cycle) -> STREAM (K+2B-2 cycles, t = 0..K+2B-3) -> DONE (1 cycle) -> IDLE.
//  - load_ready_o = (state==IDLE). Each accepted beat writes entry k = the per-matrix counter, then increments that counter.
//    Writing entry K-1 sets that matrix's full flag. The counter wraps to 0.
//  - A beat to an already-full matrix overwrites from k=0. The full flag stays set.
//  - start_i in IDLE with a_full&w_full goes to CLEAR. Otherwise start_i is ignored: no error, no latch.
//    start_i outside IDLE is ignored.
//  - start_i and load beat in same IDLE cycle: the beat is written. start uses the full flags sampled BEFORE that beat.
//  - CLEAR: acc_clr_o=1, data_o=weight_o=0.
//  - STREAM, cycle t (registered outputs, valid during the cycle):
//    data_o lane r = A[r][t-r] if 0 <= t-r < K, else 0.
//    weight_o lane c = W[t-c][c] if 0 <= t-c < K, else 0.
//    Zero fill lets the trailing PEs accumulate 0 while the wavefront drains.
//  - The last product reaches PE(B-1,B-1) at t = K+2B-3. It is registered at that edge, so results are stable in DONE.
//  - DONE: done_o=1, data_o=weight_o=0. Leaving DONE clears a_full and w_full and resets both counters.
//  - Latency: start accepted at edge e0; acc_clr_o high in cycle 1; done_o high in cycle K+2B. B=K=4 gives 12.
//  - Operands pass through unmodified: no sign handling or arithmetic in the feeder.
//    The PEs do signed QWxQW multiply and accumulate, 2*QW wrap.
//  - Stream counter width $clog2(K+2B). No counter may wrap within STREAM.
// CONFIGURATION
//  FEEDER_WEIGHT_HOLD_EN defined: leaving DONE clears only a_full and the A counter. W stays loaded, giving
//   weight-stationary reuse. A new start needs only a reloaded A. W beats still overwrite from W counter position.
//  Undefined: both matrices are cleared after DONE, and each start requires a full reload of A and W.
// TESTING (B=4, K=4, QW=8, 4x4 DP array attached)
//  1. Reset held 2 cycles -> load_ready_o=1, busy_o=0, done_o=0, acc_clr_o=0, data_o=weight_o=0.
//  2. A[r][k]=4r+k+1, W=identity, start -> acc_clr_o high 1 cycle, done_o 12 cycles after start,
//     PE(r,c).result = A[r][c] (e.g. PE(3,0)=13).
//  3. Skew check, same load: t=0 data lane0=1, others 0. t=1 data lanes 0,1 = 2,5.
//     t=3 data lane3=13. t=9 all lanes 0. weight lane1 at t=1 = W[0][1] = 0.
//  4. Load A only, pulse start -> stays IDLE, busy_o=0, no acc_clr_o. Then load W and start -> normal run.
//  5. All A=0x80, all W=0x7F -> every PE.result = 4*(-16256) mod 2^16 = 16'h0200.
//  6. Reset at STREAM t=3 -> next cycle data_o=weight_o=0, load_ready_o=1. start without reload is ignored.
//  7. With FEEDER_WEIGHT_HOLD_EN: run test 2, reload A only with A=2*A, start -> runs, PE(3,0)=26.
//     Without the macro the same start is ignored.

Source files
------------

// File: rtl/systolic_feeder.sv
// Operand feeder for a B x B systolic PE array: buffers A and W, then streams them diagonally skewed.
// Build option FEEDER_WEIGHT_HOLD_EN keeps W loaded across runs for weight-stationary reuse.
//
// state    | meaning
// S_IDLE   | accepting load beats, waiting for start with both matrices full
// S_CLEAR  | one cycle of accumulator clear to the array
// S_STREAM | skewed operand wavefront, t = 0..K+2B-3
// S_DONE   | one cycle done pulse, array results final
module systolic_feeder #(
  parameter int B               = 4,
  parameter int K               = 4,
  parameter int quantized_width = 8
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic                         load_valid_i,
  output logic                         load_ready_o,
  input  logic                         load_sel_i,
  input  logic [B*quantized_width-1:0] load_data_i,
  input  logic                         start_i,
  output logic                         busy_o,
  output logic                         acc_clr_o,
  output logic [B*quantized_width-1:0] data_o,
  output logic [B*quantized_width-1:0] weight_o,
  output logic                         done_o
);
  localparam int QW     = quantized_width;
  localparam int TW     = $clog2(K + 2*B);
  localparam int KCW    = (K > 1) ? $clog2(K) : 1;
  localparam int T_LAST = K + 2*B - 3;

  typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_STREAM, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   t_q, t_d;
  logic [KCW-1:0]  a_cnt_q, a_cnt_d, w_cnt_q, w_cnt_d;
  logic            a_full_q, a_full_d, w_full_q, w_full_d;
  logic [B*QW-1:0] data_q, data_d, weight_q, weight_d;
  logic [QW-1:0]   a_buf_q [B][K];
  logic [QW-1:0]   a_buf_d [B][K];
  logic [QW-1:0]   w_buf_q [K][B];
  logic [QW-1:0]   w_buf_d [K][B];
  int              tn;

  always_comb begin
    state_d  = state_q;
    t_d      = t_q;
    a_cnt_d  = a_cnt_q;
    w_cnt_d  = w_cnt_q;
    a_full_d = a_full_q;
    w_full_d = w_full_q;
    a_buf_d  = a_buf_q;
    w_buf_d  = w_buf_q;
    data_d   = '0;
    weight_d = '0;
    tn       = -1;
    case (state_q)
      S_IDLE: begin
        if (load_valid_i && !load_sel_i) begin
          for (int k = 0; k < K; k++)
            if (a_cnt_q == KCW'(k))
              for (int i = 0; i < B; i++) a_buf_d[i][k] = load_data_i[i*QW +: QW];
          a_cnt_d = (a_cnt_q == KCW'(K-1)) ? '0 : a_cnt_q + KCW'(1);
          if (a_cnt_q == KCW'(K-1)) a_full_d = 1'b1;
        end
        if (load_valid_i && load_sel_i) begin
          for (int k = 0; k < K; k++)
            if (w_cnt_q == KCW'(k))
              for (int i = 0; i < B; i++) w_buf_d[k][i] = load_data_i[i*QW +: QW];
          w_cnt_d = (w_cnt_q == KCW'(K-1)) ? '0 : w_cnt_q + KCW'(1);
          if (w_cnt_q == KCW'(K-1)) w_full_d = 1'b1;
        end
        // start looks at the full flags before any beat landing this same cycle
        if (start_i && a_full_q && w_full_q) state_d = S_CLEAR;
      end
      S_CLEAR: begin
        state_d = S_STREAM;
        t_d     = '0;
        tn      = 0;
      end
      S_STREAM: begin
        if (t_q == TW'(T_LAST)) begin
          state_d = S_DONE;
        end else begin
          t_d = t_q + TW'(1);
          tn  = int'(t_q) + 1;
        end
      end
      S_DONE: begin
        state_d  = S_IDLE;
        a_full_d = 1'b0;
        a_cnt_d  = '0;
`ifndef FEEDER_WEIGHT_HOLD_EN
        w_full_d = 1'b0;
        w_cnt_d  = '0;
`endif
      end
      default: state_d = S_IDLE;
    endcase
    // outputs for the coming stream cycle tn; lanes outside the wavefront stay 0
    for (int r = 0; r < B; r++)
      for (int k = 0; k < K; k++) begin
        if (tn == r + k) data_d[r*QW +: QW]   = a_buf_q[r][k];
        if (tn == r + k) weight_d[r*QW +: QW] = w_buf_q[k][r];
      end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= S_IDLE;
      t_q      <= '0;
      a_cnt_q  <= '0;
      w_cnt_q  <= '0;
      a_full_q <= 1'b0;
      w_full_q <= 1'b0;
      data_q   <= '0;
      weight_q <= '0;
    end else begin
      state_q  <= state_d;
      t_q      <= t_d;
      a_cnt_q  <= a_cnt_d;
      w_cnt_q  <= w_cnt_d;
      a_full_q <= a_full_d;
      w_full_q <= w_full_d;
      data_q   <= data_d;
      weight_q <= weight_d;
    end
  end

  always_ff @(posedge clk_i) begin
    a_buf_q <= a_buf_d;
    w_buf_q <= w_buf_d;
  end

  assign load_ready_o = (state_q == S_IDLE);
  assign busy_o       = (state_q == S_CLEAR) || (state_q == S_STREAM);
  assign acc_clr_o    = (state_q == S_CLEAR);
  assign done_o       = (state_q == S_DONE);
  assign data_o       = data_q;
  assign weight_o     = weight_q;
endmodule

// File: tb/tb_systolic_feeder.sv
// Scoreboard bench for systolic_feeder (B=K=4, QW=8) with a behavioural 4x4 DP array on its outputs.
// Honours FEEDER_WEIGHT_HOLD_EN when the design is built with it.
module tb_systolic_feeder;
  localparam int B = 4, K = 4, QW = 8, NT = K + 2*B - 2;

  logic clk_i = 1'b0, reset_i = 1'b1, load_valid_i = 1'b0, load_sel_i = 1'b0, start_i = 1'b0;
  logic [B*QW-1:0] load_data_i = '0;
  logic load_ready_o, busy_o, acc_clr_o, done_o;
  logic [B*QW-1:0] data_o, weight_o;

  systolic_feeder #(.B(B), .K(K), .quantized_width(QW)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .load_valid_i(load_valid_i), .load_ready_o(load_ready_o),
    .load_sel_i(load_sel_i), .load_data_i(load_data_i), .start_i(start_i), .busy_o(busy_o),
    .acc_clr_o(acc_clr_o), .data_o(data_o), .weight_o(weight_o), .done_o(done_o));

  always #5 clk_i = ~clk_i;

  typedef struct packed { logic [31:0] d; logic [31:0] w; } vec_t;
  vec_t         exp_stream [$];
  logic [255:0] exp_res [$];
  int n_checks = 0, n_fail = 0, cyc = 0, clr_cyc = 0, done_cnt = 0;

  logic [7:0]         am [4][4];
  logic [7:0]         wm [4][4];
  logic [15:0]        er [4][4];
  logic signed [7:0]  pa [4][4];
  logic signed [7:0]  pw [4][4];
  logic signed [7:0]  na [4][4];
  logic signed [7:0]  nw [4][4];
  logic signed [15:0] acc [4][4];
  vec_t               mon_e;
  logic [255:0]       mon_r;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic pe_step();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        if (c == 0) na[r][c] = data_o[r*8 +: 8];
        else        na[r][c] = pa[r][c-1];
        if (r == 0) nw[r][c] = weight_o[c*8 +: 8];
        else        nw[r][c] = pw[r-1][c];
        acc[r][c] = acc[r][c] + na[r][c] * nw[r][c];
      end
    pa = na;
    pw = nw;
  endtask

  // monitor: pops expectations whenever the DUT presents stream data or done
  always @(negedge clk_i) begin
    cyc++;
    if (!reset_i) begin
      if (acc_clr_o) begin
        clr_cyc = cyc;
        chk("clr_busy", 64'(busy_o), 64'd1);
        chk("clr_zero_out", {data_o, weight_o}, 64'd0);
        for (int r = 0; r < 4; r++)
          for (int c = 0; c < 4; c++) begin acc[r][c] = '0; pa[r][c] = '0; pw[r][c] = '0; end
      end else if (busy_o) begin
        if (exp_stream.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL stream_unexpected: got data %0h weight %0h expected no stream", data_o, weight_o);
        end else begin
          mon_e = exp_stream.pop_front();
          chk("stream_data", 64'(data_o), 64'(mon_e.d));
          chk("stream_weight", 64'(weight_o), 64'(mon_e.w));
        end
        pe_step();
      end
      if (done_o) begin
        done_cnt++;
        chk("done_latency", 64'(cyc - clr_cyc), 64'd11);
        chk("done_zero_out", {data_o, weight_o}, 64'd0);
        if (exp_res.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL done_unexpected: got done_o=1 expected no done");
        end else begin
          mon_r = exp_res.pop_front();
          for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
              chk($sformatf("pe_result_%0d_%0d", r, c), 64'(acc[r][c]), 64'(mon_r[(r*4+c)*16 +: 16]));
        end
      end
    end
  end

  task automatic beat(input logic sel, input logic [31:0] d);
    load_valid_i = 1'b1; load_sel_i = sel; load_data_i = d;
    @(posedge clk_i); #1;
    load_valid_i = 1'b0;
  endtask

  task automatic load_a();
    logic [31:0] d;
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 4; i++) d[i*8 +: 8] = am[i][k];
      beat(1'b0, d);
    end
  endtask

  task automatic load_w();
    logic [31:0] d;
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 4; i++) d[i*8 +: 8] = wm[k][i];
      beat(1'b1, d);
    end
  endtask

  task automatic push_run(input int nt, input bit with_res);
    vec_t e;
    logic [255:0] rv;
    for (int t = 0; t < nt; t++) begin
      e = '0;
      for (int l = 0; l < 4; l++) begin
        if (t - l >= 0 && t - l < K) e.d[l*8 +: 8] = am[l][t-l];
        if (t - l >= 0 && t - l < K) e.w[l*8 +: 8] = wm[t-l][l];
      end
      exp_stream.push_back(e);
    end
    if (with_res) begin
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) rv[(r*4+c)*16 +: 16] = er[r][c];
      exp_res.push_back(rv);
    end
  endtask

  task automatic do_start();
    start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
  endtask

  task automatic wait_done();
    int d0 = done_cnt;
    for (int i = 0; i < 40 && done_cnt == d0; i++) @(posedge clk_i);
    if (done_cnt == d0) begin
      n_checks++; n_fail++;
      $display("FAIL done_timeout: got no done_o in 40 cycles expected done");
    end
    #1;
  endtask

  task automatic check_idle(input string name, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_i); #1;
      chk({name, "_busy"}, 64'(busy_o), 64'd0);
      chk({name, "_clr"}, 64'(acc_clr_o), 64'd0);
    end
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    reset_i = 1'b0;
    exp_stream.delete();
    exp_res.delete();
  endtask

  task automatic set_basic();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        am[r][c] = 8'(4*r + c + 1);
        wm[r][c] = (r == c) ? 8'd1 : 8'd0;
        er[r][c] = 16'(4*r + c + 1);
      end
  endtask

  initial begin
    // reset state
    do_reset();
    chk("rst_ready", 64'(load_ready_o), 64'd1);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_done", 64'(done_o), 64'd0);
    chk("rst_clr", 64'(acc_clr_o), 64'd0);
    chk("rst_out", {data_o, weight_o}, 64'd0);

    // A[r][k]=4r+k+1 times identity: results equal A, stream checks the skew
    set_basic();
    load_a(); load_w();
    push_run(NT, 1'b1);
    do_start();
    wait_done();
    chk("after_run_ready", 64'(load_ready_o), 64'd1);

    // reload A only with 2*A: runs only when W is held
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin am[r][c] = 8'(2*(4*r + c + 1)); er[r][c] = 16'(2*(4*r + c + 1)); end
    load_a();
`ifdef FEEDER_WEIGHT_HOLD_EN
    push_run(NT, 1'b1);
    do_start();
    wait_done();
`else
    do_start();
    check_idle("reuse_ignored", 4);
`endif

    // A only then start is ignored; adding W makes the same start work
    do_reset();
    set_basic();
    load_a();
    do_start();
    check_idle("a_only", 4);
    load_w();
    push_run(NT, 1'b1);
    do_start();
    wait_done();

    // signed extremes: 4 * (-128 * 127) wraps to 0x0200
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin am[r][c] = 8'h80; wm[r][c] = 8'h7F; er[r][c] = 16'h0200; end
    load_a(); load_w();
    push_run(NT, 1'b1);
    do_start();
    wait_done();

    // reset during stream cycle t=3
    set_basic();
    load_a(); load_w();
    push_run(3, 1'b0);
    do_start();
    repeat (4) begin @(posedge clk_i); #1; end
    reset_i = 1'b1;
    @(posedge clk_i); #1;
    reset_i = 1'b0;
    chk("midrst_out", {data_o, weight_o}, 64'd0);
    chk("midrst_ready", 64'(load_ready_o), 64'd1);
    chk("midrst_busy", 64'(busy_o), 64'd0);
    chk("midrst_consumed", 64'(exp_stream.size()), 64'd0);
    exp_stream.delete();
    do_start();
    check_idle("midrst_start", 4);

    repeat (2) @(posedge clk_i);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
